// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer constants and arbiter state type.
// FB_PIXELS is also used by the VGA timing generator.
package vga_pkg;

   localparam int unsigned H_DISPLAY = 1920;
   localparam int unsigned V_DISPLAY = 1080;
   localparam int unsigned ADDR_W    = 21;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned COL_W     = 11;
   localparam int unsigned FB_PIXELS = H_DISPLAY * V_DISPLAY;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StHost
   } fb_state_e;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Line prefetch address generator: base latch, column counter, burst counter.
// col saturates at the last pixel; burst saturates at BURST until cleared by a host slot.
module vga_fb_addr_gen
   import vga_pkg::*;
#(
   parameter int unsigned BURST = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [COL_W-1:0]  line_idx,
   input  logic              step,
   input  logic              burst_clr,
   output logic [ADDR_W-1:0] addr,
   output logic [COL_W-1:0]  col,
   output logic              last,
   output logic              burst_full
);

   localparam int unsigned BURST_W = $clog2(BURST + 1);

   logic [ADDR_W-1:0]  base_q;
   logic [COL_W-1:0]   col_q;
   logic [BURST_W-1:0] burst_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q  <= '0;
         col_q   <= '0;
         burst_q <= '0;
      end else begin
         if (load) begin
            base_q <= ADDR_W'(line_idx) * ADDR_W'(H_DISPLAY);
            col_q  <= '0;
         end else if (step && !last) begin
            col_q <= col_q + 1'b1;
         end
         if (load || burst_clr) begin
            burst_q <= '0;
         end else if (step && !burst_full) begin
            burst_q <= burst_q + 1'b1;
         end
      end
   end

   assign addr       = base_q + ADDR_W'(col_q);
   assign col        = col_q;
   assign last       = (col_q == COL_W'(H_DISPLAY - 1));
   assign burst_full = (burst_q == BURST_W'(BURST));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: display line prefetch (priority) vs host pixel writes.
// state_q names the access currently presented on the registered mem_* outputs.
module vga_fb_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned BURST = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              line_req,
   input  logic [COL_W-1:0]  line_idx,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              pf_wvalid,
   output logic [COL_W-1:0]  pf_waddr,
   output logic [DATA_W-1:0] pf_wdata,
   output logic              pf_done,
   output logic              pf_overrun
);

   fb_state_e         state_q;
   logic              pending_q;
   logic [COL_W-1:0]  rd_col_q;
   logic              rd_last_q;

   logic [ADDR_W-1:0] gen_addr;
   logic [COL_W-1:0]  gen_col;
   logic              gen_last;
   logic              burst_full;
   logic              line_accept;
   logic              host_ok;
   logic              do_read;
   logic              do_host;
   logic              host_in_range;

   assign line_accept   = line_req && (line_idx < COL_W'(V_DISPLAY)) && !pending_q;
   // The request is still high during its own ack cycle, so it is ignored there.
   assign host_ok       = host_req && (state_q != StHost);
   assign do_read       = pending_q && !(burst_full && host_ok);
   assign do_host       = host_ok && (pending_q ? burst_full : !line_accept);
   assign host_in_range = host_addr < ADDR_W'(FB_PIXELS);

   vga_fb_addr_gen #(
      .BURST (BURST)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load       (line_accept),
      .line_idx   (line_idx),
      .step       (do_read),
      .burst_clr  (do_host),
      .addr       (gen_addr),
      .col        (gen_col),
      .last       (gen_last),
      .burst_full (burst_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         pending_q  <= 1'b0;
         rd_col_q   <= '0;
         rd_last_q  <= 1'b0;
         host_ack   <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         pf_wvalid  <= 1'b0;
         pf_waddr   <= '0;
         pf_done    <= 1'b0;
         pf_overrun <= 1'b0;
      end else begin
         host_ack   <= do_host;
         pf_overrun <= line_req && pending_q;
         // Read data returns one cycle after the strobe, so the line-buffer write trails it.
         pf_wvalid  <= (state_q == StFetch);
         pf_done    <= (state_q == StFetch) && rd_last_q;
         if (state_q == StFetch) begin
            pf_waddr <= rd_col_q;
         end

         if (line_accept) begin
            pending_q <= 1'b1;
         end else if (do_read && gen_last) begin
            pending_q <= 1'b0;
         end

         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if (do_read) begin
            state_q   <= StFetch;
            mem_en    <= 1'b1;
            mem_addr  <= gen_addr;
            rd_col_q  <= gen_col;
            rd_last_q <= gen_last;
         end else if (do_host) begin
            state_q   <= StHost;
            mem_en    <= host_in_range;
            mem_we    <= host_in_range;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
         end else begin
            state_q <= StIdle;
         end
      end
   end

   assign pf_wdata = pf_wvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a synchronous RAM model and a negedge monitor.
module tb_vga_fb_arbiter;
   import vga_pkg::*;

   logic              clk;
   logic              reset;
   logic              line_req;
   logic [COL_W-1:0]  line_idx;
   logic              host_req;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              pf_wvalid;
   logic [COL_W-1:0]  pf_waddr;
   logic [DATA_W-1:0] pf_wdata;
   logic              pf_done;
   logic              pf_overrun;

   int n_checks = 0;
   int n_fail   = 0;

   vga_fb_arbiter #(
      .BURST (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .line_req   (line_req),
      .line_idx   (line_idx),
      .host_req   (host_req),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .pf_wvalid  (pf_wvalid),
      .pf_waddr   (pf_waddr),
      .pf_wdata   (pf_wdata),
      .pf_done    (pf_done),
      .pf_overrun (pf_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]};
   endfunction

   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Monitor state
   int cyc = 0;
   int rd_cnt, rd_err, wv_cnt, wv_err, done_cnt, done_ok, ack_cnt, ack_in_win, ovr_cnt, en_cnt;
   int first_rd_addr, last_rd_addr, first_rd_cyc, last_rd_cyc, rd_at_ack1;
   logic [ADDR_W-1:0] exp_rd, mon_base, ack1_addr;
   logic [COL_W-1:0]  exp_col;
   logic              ack1_we, ack1_en;

   task automatic mon_clear(input logic [ADDR_W-1:0] base);
      rd_cnt = 0; rd_err = 0; wv_cnt = 0; wv_err = 0; done_cnt = 0; done_ok = 0;
      ack_cnt = 0; ack_in_win = 0; ovr_cnt = 0; en_cnt = 0;
      first_rd_addr = -1; last_rd_addr = -1; first_rd_cyc = 0; last_rd_cyc = 0; rd_at_ack1 = -1;
      exp_rd = base; mon_base = base; exp_col = '0;
      ack1_addr = '0; ack1_we = 1'b0; ack1_en = 1'b0;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (mem_en) en_cnt++;
      if (mem_en && !mem_we) begin
         if (rd_cnt == 0) begin
            first_rd_addr = int'(mem_addr);
            first_rd_cyc  = cyc;
         end
         if (mem_addr !== exp_rd) rd_err++;
         exp_rd       = exp_rd + 1'b1;
         rd_cnt++;
         last_rd_addr = int'(mem_addr);
         last_rd_cyc  = cyc;
      end
      if (pf_wvalid) begin
         if (pf_waddr !== exp_col || pf_wdata !== pat(mon_base + ADDR_W'(pf_waddr))) wv_err++;
         exp_col = exp_col + 1'b1;
         wv_cnt++;
      end
      if (pf_done) begin
         done_cnt++;
         if (pf_wvalid && pf_waddr == COL_W'(H_DISPLAY - 1)) done_ok++;
      end
      if (host_ack) begin
         ack_cnt++;
         if (ack_cnt == 1) begin
            rd_at_ack1 = rd_cnt;
            ack1_addr  = mem_addr;
            ack1_we    = mem_we;
            ack1_en    = mem_en;
         end
         if (rd_cnt > 0 && rd_cnt < int'(H_DISPLAY)) ack_in_win++;
      end
      if (pf_overrun) ovr_cnt++;
   end

   task automatic pulse_line(input int idx);
      line_idx = COL_W'(idx);
      line_req = 1'b1;
      @(negedge clk);
      line_req = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int n = 0;
      while (done_cnt == 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check("done_within_budget", 32'(done_cnt != 0), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctl"}, 32'({host_ack, mem_en, mem_we, pf_wvalid, pf_done, pf_overrun}), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_pf_waddr"}, 32'(pf_waddr), 32'd0);
      check({tag, "_pf_wdata"}, 32'(pf_wdata), 32'd0);
   endtask

   initial begin
      int n;
      int gap;
      reset      = 1'b0;
      line_req   = 1'b0;
      line_idx   = '0;
      host_req   = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      mon_clear('0);
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // Plain prefetch of line 2
      mon_clear(21'd3840);
      pulse_line(2);
      wait_done(2100);
      check("pf_first_addr", 32'(first_rd_addr), 32'd3840);
      check("pf_last_addr", 32'(last_rd_addr), 32'd5759);
      check("pf_read_count", 32'(rd_cnt), 32'd1920);
      check("pf_read_order_errs", 32'(rd_err), 32'd0);
      check("pf_wvalid_count", 32'(wv_cnt), 32'd1920);
      check("pf_waddr_wdata_errs", 32'(wv_err), 32'd0);
      check("pf_done_count", 32'(done_cnt), 32'd1);
      check("pf_done_with_last", 32'(done_ok), 32'd1);
      check("pf_window", 32'(last_rd_cyc - first_rd_cyc + 1), 32'd1920);
      check("pf_no_host_ack", 32'(ack_cnt), 32'd0);

      // line_req and host_req together, host held for the whole line
      mon_clear(21'd0);
      host_addr  = 21'd1234;
      host_wdata = 8'h5a;
      host_req   = 1'b1;
      pulse_line(0);
      wait_done(2200);
      host_req = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_first_addr", 32'(first_rd_addr), 32'd0);
      check("pre_reads_before_ack", 32'(rd_at_ack1), 32'd16);
      check("pre_ack_we", 32'(ack1_we), 32'd1);
      check("pre_ack_en", 32'(ack1_en), 32'd1);
      check("pre_ack_addr", 32'(ack1_addr), 32'd1234);
      check("pre_read_order_errs", 32'(rd_err), 32'd0);
      check("pre_read_count", 32'(rd_cnt), 32'd1920);
      check("pre_host_slots", 32'(ack_in_win), 32'd119);
      check("pre_window", 32'(last_rd_cyc - first_rd_cyc + 1), 32'd2039);
      check("pre_pf_errs", 32'(wv_err), 32'd0);
      check("pre_done_count", 32'(done_cnt), 32'd1);

      // Out-of-range line index is ignored
      mon_clear(21'd0);
      pulse_line(1080);
      repeat (20) @(negedge clk);
      check("badline_mem_en", 32'(en_cnt), 32'd0);
      check("badline_done", 32'(done_cnt), 32'd0);
      check("badline_overrun", 32'(ovr_cnt), 32'd0);

      // Out-of-range host address: ack without RAM enable
      host_addr  = 21'd2073600;
      host_wdata = 8'h77;
      host_req   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!host_ack && n < 20);
      check("badaddr_ack", 32'(host_ack), 32'd1);
      check("badaddr_mem_en", 32'(mem_en), 32'd0);
      host_req = 1'b0;
      repeat (4) @(negedge clk);

      // Overrun: second line_req during an active fetch is dropped
      mon_clear(21'd9600);
      pulse_line(5);
      repeat (100) @(negedge clk);
      pulse_line(9);
      wait_done(2100);
      check("ovr_pulse_cycles", 32'(ovr_cnt), 32'd1);
      check("ovr_first_addr", 32'(first_rd_addr), 32'd9600);
      check("ovr_last_addr", 32'(last_rd_addr), 32'd11519);
      check("ovr_read_count", 32'(rd_cnt), 32'd1920);
      check("ovr_read_order_errs", 32'(rd_err), 32'd0);
      check("ovr_done_count", 32'(done_cnt), 32'd1);

      // Reset in the middle of a fetch of line 3
      mon_clear(21'd5760);
      pulse_line(3);
      n = 0;
      while (rd_cnt < 500 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("rst_col500_reached", 32'(rd_cnt >= 500), 32'd1);
      reset = 1'b0;
      #1;
      check_outputs_zero("midrst");
      repeat (3) @(negedge clk);
      check("midrst_no_done", 32'(done_cnt), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      mon_clear(21'd13440);
      pulse_line(7);
      n = 0;
      while (rd_cnt == 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("postrst_first_addr", 32'(first_rd_addr), 32'd13440);
      wait_done(2100);
      check("postrst_last_addr", 32'(last_rd_addr), 32'd15359);
      check("postrst_read_order_errs", 32'(rd_err), 32'd0);

      // Ten back-to-back host writes from idle
      host_addr  = 21'd7;
      host_wdata = 8'd3;
      host_req   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (!host_ack && gap < 10);
         check("tp_ack", 32'(host_ack), 32'd1);
         if (i > 0) check("tp_ack_spacing", 32'(gap), 32'd2);
         check("tp_addr", 32'(mem_addr), 32'(i * 1000 + 7));
         check("tp_wdata", 32'(mem_wdata), 32'((i * 17 + 3) % 256));
         check("tp_we_en", 32'({mem_we, mem_en}), 32'd3);
         if (i < 9) begin
            host_addr  = ADDR_W'((i + 1) * 1000 + 7);
            host_wdata = DATA_W'(((i + 1) * 17 + 3) % 256);
         end else begin
            host_req = 1'b0;
         end
      end
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Arbitrates the single-port 8-bit frame-buffer memory (1920x1080 pixels, one byte per pixel) between two requesters:
  - display line prefetch, which fills the scan-out line buffer ahead of the VGA timing generator;
  - host pixel writes from the image/text-extraction path.
- Prefetch has priority. The host is guaranteed a write slot after every burst of reads, so neither side starves.
- Sits between the VGA timing/line-buffer logic and the frame-buffer RAM.

Parameters:
- H_DISPLAY, 1920, pixels per line
- V_DISPLAY, 1080, lines per frame
- ADDR_W, 21, frame-buffer address width (1920*1080 = 2073600 < 2^21)
- DATA_W, 8, pixel width
- COL_W, 11, line-buffer column width
- BURST, 16, prefetch reads issued before a pending host write is granted

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- line_req  in  1  one-cycle pulse: prefetch display line line_idx
- line_idx  in  11  line number, sampled when line_req=1
- host_req  in  1  host write request; held high until host_ack
- host_addr  in  ADDR_W  pixel address
- host_wdata  in  DATA_W  pixel value
- host_ack  out  1  one-cycle pulse: host write accepted
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; valid 1 cycle after a read strobe
- pf_wvalid  out  1  line-buffer write strobe
- pf_waddr  out  COL_W  line-buffer column
- pf_wdata  out  DATA_W  line-buffer data (= mem_rdata)
- pf_done  out  1  pulse: line prefetch complete
- pf_overrun  out  1  pulse: line_req arrived while a fetch was busy or pending

Behaviour:
- Reset (reset=0):
  - all outputs 0; state=IDLE; column counter 0; pending flag 0; burst counter 0.
  - Asserting reset mid-fetch abandons the line: no pf_done is issued.
- State encoding: IDLE, FETCH, HOST. All mem_* outputs, host_ack, pf_done and pf_overrun are registered.
- line_req acceptance:
  - Valid line_req (line_idx < V_DISPLAY) when no fetch is active or pending: latch base = line_idx*H_DISPLAY, col=0, set the pending flag.
  - line_idx >= V_DISPLAY: the request is ignored; no memory activity, no pf_done.
- line_req overrun: when a fetch is already active or pending, pf_overrun pulses 1 cycle, the new request is dropped, and the current fetch continues unchanged.
- IDLE transitions:
  - pending -> FETCH;
  - else host_req -> HOST;
  - a line_req in the same cycle as host_req wins (becomes pending, goes to FETCH).
- FETCH:
  - Each cycle issues one read: mem_en=1, mem_we=0, mem_addr = base+col. Then col++ and the burst count increments.
  - One cycle later: pf_wvalid=1, pf_waddr = col of that read, pf_wdata = mem_rdata.
  - After the read of col=H_DISPLAY-1: clear the pending flag and go to IDLE. pf_done pulses in the same cycle as the final pf_wvalid.
  - After BURST reads with host_req=1 and the line not finished: go to HOST and clear the burst count.
- HOST:
  - Lasts exactly 1 cycle: mem_en=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata, host_ack=1.
  - If host_addr >= H_DISPLAY*V_DISPLAY: host_ack still pulses, but mem_en=0 (write dropped).
  - Returns to FETCH if a fetch is active or pending, else to IDLE.
- Host handshake:
  - The requester deasserts, or presents the next transaction, in the cycle after host_ack. The block ignores host_req in the cycle after an ack, so the maximum host rate is 1 write per 2 cycles.
  - host_req is never granted mid-burst.
- Worst-case line fetch is H_DISPLAY + H_DISPLAY/BURST cycles = 2040, which fits inside the 2200-cycle line period.
- Arithmetic: base+col is computed at ADDR_W bits with no wrap (max 2073599). The col counter saturates logic at H_DISPLAY-1 and never wraps inside a line.

Decomposition:
- Shared package vga_pkg holds:
  - H_DISPLAY, V_DISPLAY, ADDR_W, DATA_W, COL_W;
  - the state enum type (IDLE/FETCH/HOST);
  - the FB_PIXELS = H_DISPLAY*V_DISPLAY constant, reused by the VGA timing generator.
- One natural sub-module, vga_fb_addr_gen: base latch, column counter and burst counter, with done/burst-boundary flags. The FSM and handshake stay in the top level.

Test Plan:
- Prefetch: line_req, line_idx=2, no host traffic. Required:
  - first mem_addr=3840;
  - 1920 consecutive reads, last read at 5759;
  - pf_waddr 0..1919 in order;
  - pf_done pulses exactly once, with the final pf_wvalid.
- Host preemption: host_req held during a fetch of line 0. Required:
  - first write slot after 16 reads (mem_addr 0..15);
  - host_ack pulses with mem_we=1 and mem_addr=host_addr;
  - the fetch resumes at address 16.
- Simultaneous requests: line_req and host_req in the same IDLE cycle. Required:
  - FETCH first;
  - host served after the first burst;
  - total fetch time 1920 + number of host slots.
- Boundaries:
  - line_idx=1080 -> no mem_en, no pf_done;
  - host_addr=2073600 -> host_ack=1 with mem_en=0;
  - line_req during an active fetch -> pf_overrun for 1 cycle, and the original line completes.
- Reset mid-operation: reset=0 at col=500 of a fetch. Required:
  - all outputs 0 asynchronously;
  - no pf_done;
  - after release, a new line_req for line 7 starts at address 13440.
- Host throughput: 10 back-to-back host writes in IDLE -> acks every 2 cycles, with addresses and data matching.
